muldiv: RTL and testbench

Iterative multiply/divide unit for the MIPS core's execute stage. Executes MULT, MULTU, DIV and DIVU over 34 cycles, and holds the architectural HI/LO registers. The hi and lo outputs feed the d2 and d3 legs of the write-back result 4-to-1 mux for MFHI and MFLO. The pipeline stall logic uses busy to freeze issue while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv.sv | 123 ++++++++++++
 tb/tb_muldiv.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared multiply/divide definitions: op and state encodings, iteration count.
// Imported by the decoder and by muldiv.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    localparam int unsigned ITERS = 32;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return sgn ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One operation takes 32 shift iterations plus one sign-fix cycle.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e      state, state_nx;
    logic [63:0] acc;
    logic [5:0]  cnt;
    logic [31:0] opnd;
    logic        is_div;
    logic        sign_a, sign_b;

    logic        in_signed, in_div;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign in_signed = (op == MD_MULT) || (op == MD_DIV);
    assign in_div    = (op == MD_DIV) || (op == MD_DIVU);
    assign abs_a     = mag(a, in_signed && a[31]);
    assign abs_b     = mag(b, in_signed && b[31]);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_CALC;
            S_CALC:  if (cnt == 6'(ITERS - 1)) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Multiply: add multiplicand into the upper half, then shift right.
    // Divide: the shifted partial remainder needs 33 bits before the trial subtract.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        rem_sh   = acc[63:31];
        rem_ge   = (rem_sh >= {1'b0, opnd});
        rem_sub  = rem_sh[31:0] - opnd;
        prod_fix = (sign_a ^ sign_b) ? (64'd0 - acc) : acc;
        quo_fix  = (sign_a ^ sign_b) ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix  = sign_a ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div <= in_div;
                        sign_a <= in_signed && a[31];
                        sign_b <= in_signed && b[31];
                        cnt    <= '0;
                        opnd   <= in_div ? abs_b : abs_a;
                        acc    <= {32'd0, in_div ? abs_a : abs_b};
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 6'd1;
                    if (is_div) begin
                        if (rem_ge) acc <= {rem_sub, acc[30:0], 1'b1};
                        else        acc <= {acc[62:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        // A zero divisor leaves the dividend as remainder.
                        hi <= rem_fix;
                        lo <= (opnd == 32'd0) ? 32'hFFFF_FFFF : quo_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: directed spec cases plus randomized ops
// against an arithmetic reference model.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        hi_we, lo_we;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          errors = 0;
    int          checks = 0;
    int          done_count = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    always #5 clk = ~clk;

    muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Returns {hi, lo} from the architectural definition of each op.
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'b00: begin
                p = sx * sy;
                return p;
            end
            2'b01: begin
                p = {32'd0, x} * {32'd0, y};
                return p;
            end
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result");
            end else begin
                exp_e = exp_q.pop_front();
                check("result_hi", hi, exp_e[63:32]);
                check("result_lo", lo, exp_e[31:0]);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected 0 within 100 cycles");
        end
    endtask

    // Returns at the negedge just after the start edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit push);
        wait_idle();
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (push) exp_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    logic [31:0] ra, rb;
    int          bc, dc;
    logic [31:0] specials[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00;
        a = '0; b = '0; wdata = '0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // MULTU max*max with busy/done timing
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        bc = 0;
        while (busy && bc < 100) begin
            if (bc == 16) check("hold_hi_busy", hi, 32'd0);
            bc++;
            @(negedge clk);
        end
        check("busy_samples", bc, 32'd33);
        check("done_pulse", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(2'b11, 32'd7, 32'd2, 1'b1);
        issue(2'b11, 32'h0000_1234, 32'd0, 1'b1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1);
        drain();

        // MTHI / MTLO in IDLE
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h0000_AAAA;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", hi, 32'h0000_AAAA);
        lo_we = 1'b1; wdata = 32'h0000_5555;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", lo, 32'h0000_5555);

        // start and lo_we while busy are ignored
        issue(2'b11, 32'd100, 32'd7, 1'b1);
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        check("busy_mtlo_ignored", lo, 32'h0000_5555);
        check("busy_hi_held", hi, 32'h0000_AAAA);
        drain();

        // start with simultaneous MTLO: write lands, then result overwrites
        wait_idle();
        lo_we = 1'b1; wdata = 32'h0000_1111;
        issue(2'b01, 32'd9, 32'd9, 1'b1);
        lo_we = 1'b0;
        check("start_mtlo_lands", lo, 32'h0000_1111);
        drain();

        // reset mid-divide discards the result
        issue(2'b10, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        dc = done_count;
        repeat (40) @(negedge clk);
        check("rst_no_done", done_count, dc);
        issue(2'b01, 32'd2, 32'd3, 1'b1);
        drain();

        // randomized back-to-back ops
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : $urandom;
            rb = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : $urandom;
            if ($urandom_range(7) == 0) rb = $urandom_range(15);
            issue(2'($urandom_range(3)), ra, rb, 1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
